// File: rtl/proc_seq_pkg.sv
// rtl/proc_seq_pkg.sv - opcodes, FSM state type and small helpers for the program sequencer
package proc_seq_pkg;

  // Instruction format III_XXX_YYY: III selects the operation
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT
  } state_t;

  function automatic logic [2:0] op_of(input logic [8:0] word);
    return word[8:6];
  endfunction

  // Completed-instruction counter sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/proc_seq_if.sv
// rtl/proc_seq_if.sv - ROM fetch and processor issue signals between sequencer and its neighbours
interface proc_seq_if #(
  parameter int AW = 5
);
  logic [AW-1:0] mem_addr;
  logic [8:0]    mem_data;
  logic [8:0]    din;
  logic          run;
  logic          done;

  // Sequencer side: drives the ROM address and the processor instruction bus
  modport master (
    output mem_addr, din, run,
    input  mem_data, done
  );

  // ROM / processor side
  modport slave (
    input  mem_addr, din, run,
    output mem_data, done
  );
endinterface

// File: rtl/proc_seq_wdog.sv
// rtl/proc_seq_wdog.sv - clearable watchdog counter flagging TIMEOUT cycles spent waiting for Done
module proc_seq_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Flag fires during the TIMEOUT-th enabled cycle, so at most TIMEOUT wait cycles elapse
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles since the last clear, holding at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign timeout_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/proc_seq.sv
// rtl/proc_seq.sv - program sequencer: fetches ROM words, issues them to the processor, tracks PC
module proc_seq
  import proc_seq_pkg::*;
#(
  parameter int AW        = 5,
  parameter int LAST_ADDR = 31,
  parameter int TIMEOUT   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  proc_seq_if.master      bus,
  output logic [AW-1:0]   pc_o,
  output logic [7:0]      instr_count_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            error_o
);

  localparam logic [AW:0] LAST_W = (AW + 1)'(LAST_ADDR);

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [7:0]    cnt_q;
  logic [8:0]    ir_q;
  logic [8:0]    imm_q;
  logic [8:0]    din_q;
  logic          run_q;
  logic          busy_q;
  logic          halted_q;
  logic          error_q;

  logic [2:0]    dec_op;
  logic          ir_is_mvi;
  logic          pc_at_last;
  logic [AW:0]   step;
  logic [AW:0]   pc_next;
  logic [AW-1:0] addr_sel;
  logic          wdog_clr;
  logic          wdog_en;
  logic          timeout;

  assign dec_op     = op_of(bus.mem_data);
  assign ir_is_mvi  = (op_of(ir_q) == OP_MVI);
  assign pc_at_last = ({1'b0, pc_q} == LAST_W);
  assign step       = ir_is_mvi ? (AW + 1)'(2) : (AW + 1)'(1);
  // One bit wider than PC so stepping past the last address is seen instead of wrapping
  assign pc_next    = {1'b0, pc_q} + step;

  assign wdog_clr = (state_q == S_ISSUE);
  assign wdog_en  = (state_q == S_WAIT_DONE);

  proc_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .timeout_o (timeout)
  );

  // ROM address: PC, except the immediate slot is requested while decoding an in-range mvi
  always_comb begin
    addr_sel = pc_q;
    if ((state_q == S_DECODE) && (dec_op == OP_MVI) && !pc_at_last) begin
      addr_sel = pc_q + AW'(1);
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.din       = din_q;
  assign bus.run       = run_q;
  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign error_o       = error_q;

  // Sequencer FSM; Run is a single-cycle strobe so it defaults low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      ir_q     <= '0;
      imm_q    <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      run_q <= 1'b0;
      if (abort_i) begin
        // Abort wins over everything, including a Done arriving on the same edge
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        halted_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_HALT: begin
            if (start_i) begin
              state_q  <= S_FETCH;
              pc_q     <= '0;
              cnt_q    <= '0;
              error_q  <= 1'b0;
              busy_q   <= 1'b1;
              halted_q <= 1'b0;
            end
          end

          S_FETCH: begin
            state_q <= S_DECODE;
          end

          S_DECODE: begin
            ir_q <= bus.mem_data;
            if (dec_op == OP_HALT) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else if ((dec_op == OP_MVI) && pc_at_last) begin
              // No ROM word left to hold the immediate
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              error_q  <= 1'b1;
            end else if (dec_op == OP_MVI) begin
              state_q <= S_FETCH_IMM;
            end else begin
              state_q <= S_ISSUE;
              din_q   <= bus.mem_data;
              run_q   <= 1'b1;
            end
          end

          S_FETCH_IMM: begin
            imm_q   <= bus.mem_data;
            din_q   <= ir_q;
            run_q   <= 1'b1;
            state_q <= S_ISSUE;
          end

          S_ISSUE: begin
            // After the strobe the processor reads the immediate for mvi, else keeps the opcode
            din_q   <= ir_is_mvi ? imm_q : ir_q;
            state_q <= S_WAIT_DONE;
          end

          S_WAIT_DONE: begin
            if (bus.done) begin
              cnt_q <= sat_inc8(cnt_q);
              if (pc_next > LAST_W) begin
                state_q  <= S_HALT;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end else begin
                pc_q    <= pc_next[AW-1:0];
                state_q <= S_FETCH;
              end
            end else if (timeout) begin
              state_q  <= S_HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              error_q  <= 1'b1;
            end
          end

          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proc_seq.sv
// tb/tb_proc_seq.sv - directed-vector bench: two sequencers with ROM and processor models
module tb_proc_seq;
  import proc_seq_pkg::*;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start;
  logic [1:0] abort;
  logic [1:0] done_en;
  logic [1:0] mon_clr;

  logic [8:0] rom_a [32];
  logic [8:0] rom_b [32];

  logic [AW-1:0] pc_w   [2];
  logic [7:0]    icnt_w [2];
  logic [1:0]    busy_w;
  logic [1:0]    halted_w;
  logic [1:0]    error_w;
  logic [1:0]    run_w;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Instance 0: LAST_ADDR=31; instance 1: LAST_ADDR=3
  for (genvar g = 0; g < 2; g++) begin : gi
    proc_seq_if #(.AW(AW)) bus ();

    logic [8:0] r [8];
    logic [8:0] acc;
    logic [8:0] gsum;
    logic       p_act;
    logic [8:0] p_ir;
    int         p_t;
    logic [2:0] px;
    logic [2:0] py;

    int         run_cnt;
    logic       addr_over;
    logic       prev_run;
    logic [8:0] prev_din;
    logic [8:0] imm_seen;

    assign px       = p_ir[5:3];
    assign py       = p_ir[2:0];
    assign run_w[g] = bus.run;

    proc_seq #(
      .AW        (AW),
      .LAST_ADDR ((g == 0) ? 31 : 3),
      .TIMEOUT   (16)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start[g]),
      .abort_i       (abort[g]),
      .bus           (bus),
      .pc_o          (pc_w[g]),
      .instr_count_o (icnt_w[g]),
      .busy_o        (busy_w[g]),
      .halted_o      (halted_w[g]),
      .error_o       (error_w[g])
    );

    always @(posedge clk) begin
      bus.mem_data <= (g == 0) ? rom_a[bus.mem_addr] : rom_b[bus.mem_addr];
    end

    always_comb begin
      bus.done = 1'b0;
      if (p_act && done_en[g]) begin
        if ((p_ir[8:6] == OP_ADD) || (p_ir[8:6] == OP_SUB)) bus.done = (p_t >= 3);
        else bus.done = 1'b1;
      end
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        p_act <= 1'b0;
        p_t   <= 0;
        p_ir  <= '0;
        acc   <= '0;
        gsum  <= '0;
        for (int i = 0; i < 8; i++) r[i] <= '0;
      end else if (bus.run) begin
        p_act <= 1'b1;
        p_ir  <= bus.din;
        p_t   <= 1;
      end else if (p_act) begin
        case (p_ir[8:6])
          OP_MV:  r[px] <= r[py];
          OP_MVI: r[px] <= bus.din;
          OP_ADD, OP_SUB: begin
            if (p_t == 1) acc <= r[px];
            if (p_t == 2) gsum <= (p_ir[8:6] == OP_ADD) ? acc + r[py] : acc - r[py];
            if (p_t == 3) r[px] <= gsum;
          end
          default: ;
        endcase
        if (bus.done) p_act <= 1'b0;
        else p_t <= p_t + 1;
      end
    end

    always @(negedge clk) begin
      if (mon_clr[g]) begin
        run_cnt   <= 0;
        addr_over <= 1'b0;
        prev_run  <= 1'b0;
        prev_din  <= '0;
        imm_seen  <= '0;
      end else begin
        if (bus.run) run_cnt <= run_cnt + 1;
        if (bus.mem_addr > AW'(3)) addr_over <= 1'b1;
        prev_run <= bus.run;
        prev_din <= bus.din;
        if (prev_run && (prev_din[8:6] == OP_MVI)) imm_seen <= bus.din;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic clear_mon(input int g);
    mon_clr[g] = 1'b1;
    @(negedge clk);
    mon_clr[g] = 1'b0;
  endtask

  task automatic wait_halt(input int g, input string tag);
    int k = 0;
    while (!halted_w[g] && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_halt_reached"}, 32'(halted_w[g]), 1);
  endtask

  task automatic wait_run(input int g, input string tag);
    int k = 0;
    while (!run_w[g] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_run_seen"}, 32'(run_w[g]), 1);
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 32; i++) rom_a[i] = 9'b111000000;
    rom_a[0] = 9'b001000000;
    rom_a[1] = 9'b000000101;
    rom_a[2] = 9'b000001000;
    rom_a[3] = 9'b010000001;
    rom_a[4] = 9'b111000000;
  endtask

  task automatic check_prog1(input string tag);
    chk({tag, "_runs"},   32'(gi[0].run_cnt),  3);
    chk({tag, "_imm"},    32'(gi[0].imm_seen), 5);
    chk({tag, "_r0"},     32'(gi[0].r[0]),     10);
    chk({tag, "_r1"},     32'(gi[0].r[1]),     5);
    chk({tag, "_icnt"},   32'(icnt_w[0]),      3);
    chk({tag, "_pc"},     32'(pc_w[0]),        4);
    chk({tag, "_halted"}, 32'(halted_w[0]),    1);
    chk({tag, "_busy"},   32'(busy_w[0]),      0);
    chk({tag, "_error"},  32'(error_w[0]),     0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    rst     = 1'b1;
    start   = '0;
    abort   = '0;
    done_en = 2'b11;
    mon_clr = 2'b11;
    load_prog1();
    for (int i = 0; i < 32; i++) rom_b[i] = 9'b000001000;
    repeat (2) @(negedge clk);

    chk("rst_pc",      32'(pc_w[0]),          0);
    chk("rst_icnt",    32'(icnt_w[0]),        0);
    chk("rst_busy",    32'(busy_w[0]),        0);
    chk("rst_halted",  32'(halted_w[0]),      0);
    chk("rst_error",   32'(error_w[0]),       0);
    chk("rst_run",     32'(run_w[0]),         0);
    chk("rst_din",     32'(gi[0].bus.din),    0);
    chk("rst_memaddr", 32'(gi[0].bus.mem_addr), 0);

    rst = 1'b0;
    @(negedge clk);
    mon_clr = 2'b00;

    // 1: mvi R0,5 ; mv R1,R0 ; add R0,R1 ; halt
    pulse_start(0);
    chk("t1_busy_after_start", 32'(busy_w[0]), 1);
    wait_halt(0, "t1");
    check_prog1("t1");

    // 2: Done never arrives -> watchdog error
    rom_a[0] = 9'b010000001;
    done_en[0] = 1'b0;
    clear_mon(0);
    pulse_start(0);
    wait_run(0, "t2");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!halted_w[0] && k < 40);
    chk("t2_latency", 32'(k), 17);
    chk("t2_error",   32'(error_w[0]), 1);
    chk("t2_halted",  32'(halted_w[0]), 1);
    chk("t2_icnt",    32'(icnt_w[0]),  0);
    chk("t2_pc",      32'(pc_w[0]),    0);

    // 5: Start ignored while busy, Abort beats a same-edge Done
    load_prog1();
    done_en[0] = 1'b1;
    pulse_start(0);
    chk("t5_error_cleared", 32'(error_w[0]), 0);
    k = 0;
    while (!(run_w[0] && pc_w[0] == AW'(2)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t5_issue_pc2", 32'(run_w[0]), 1);
    done_en[0] = 1'b0;
    repeat (3) @(negedge clk);
    pulse_start(0);
    chk("t5_pc_kept",   32'(pc_w[0]),   2);
    chk("t5_icnt_kept", 32'(icnt_w[0]), 1);
    chk("t5_busy_kept", 32'(busy_w[0]), 1);
    abort[0]   = 1'b1;
    done_en[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("t5_abort_busy",   32'(busy_w[0]),   0);
    chk("t5_abort_halted", 32'(halted_w[0]), 0);
    chk("t5_abort_run",    32'(run_w[0]),    0);
    chk("t5_abort_icnt",   32'(icnt_w[0]),   1);
    @(negedge clk);
    chk("t5_stays_idle",   32'(busy_w[0]),   0);

    // 6: async reset in WAIT_DONE, then a clean rerun of program 1
    pulse_start(0);
    wait_run(0, "t6");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pc",      32'(pc_w[0]),            0);
    chk("t6_icnt",    32'(icnt_w[0]),          0);
    chk("t6_busy",    32'(busy_w[0]),          0);
    chk("t6_halted",  32'(halted_w[0]),        0);
    chk("t6_error",   32'(error_w[0]),         0);
    chk("t6_run",     32'(run_w[0]),           0);
    chk("t6_din",     32'(gi[0].bus.din),      0);
    chk("t6_memaddr", 32'(gi[0].bus.mem_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon(0);
    pulse_start(0);
    wait_halt(0, "t6rerun");
    check_prog1("t6rerun");

    // 3: LAST_ADDR=3, all mv -> four instructions, stop at PC=3
    clear_mon(1);
    pulse_start(1);
    wait_halt(1, "t3");
    chk("t3_runs",     32'(gi[1].run_cnt),   4);
    chk("t3_icnt",     32'(icnt_w[1]),       4);
    chk("t3_pc",       32'(pc_w[1]),         3);
    chk("t3_error",    32'(error_w[1]),      0);
    chk("t3_addr_max", 32'(gi[1].addr_over), 0);

    // 4: mvi at the last address -> error, no fourth issue
    rom_b[3] = 9'b001000000;
    clear_mon(1);
    pulse_start(1);
    wait_halt(1, "t4");
    chk("t4_runs",     32'(gi[1].run_cnt),   3);
    chk("t4_icnt",     32'(icnt_w[1]),       3);
    chk("t4_pc",       32'(pc_w[1]),         3);
    chk("t4_error",    32'(error_w[1]),      1);
    chk("t4_addr_max", 32'(gi[1].addr_over), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
